// File: rtl/pipelined_control_unit_if.sv
// Bundle of the front-end/datapath-facing control signals of the pipelined control unit.
// Latency: none (wires only).
// Backpressure: none; the stall_o/flush_o outputs carry the pipeline hold/kill requests.
interface pipelined_control_unit_if #(
    parameter int OP_W    = 4,
    parameter int RA_W    = 4,
    parameter int ALUOP_W = 3,
    parameter int CNT_W   = 16
);
    logic               id_valid;
    logic [OP_W-1:0]    id_opcode;
    logic [RA_W-1:0]    id_rs1;
    logic [RA_W-1:0]    id_rs2;
    logic [RA_W-1:0]    id_rd;
    logic               alu_flagN;
    logic               alu_flagZ;
    logic               stall_o;
    logic               flush_o;
    logic               pc_sel;
    logic [ALUOP_W-1:0] ex_aluop;
    logic [1:0]         ex_ri;
    logic               ex_alu_mux;
    logic [1:0]         mem_mm;
    logic               mem_am;
    logic               mem_wme1;
    logic               wb_wre;
    logic               wb_wbs;
    logic               wb_wm;
    logic [RA_W-1:0]    wb_rd;
    logic [1:0]         flags_o;
    logic               illegal_op;
    logic [CNT_W-1:0]   stall_cnt;
    logic [CNT_W-1:0]   flush_cnt;

    // Front end / datapath side: drives the ID fields and ALU flags.
    modport master (
        output id_valid, id_opcode, id_rs1, id_rs2, id_rd, alu_flagN, alu_flagZ,
        input  stall_o, flush_o, pc_sel, ex_aluop, ex_ri, ex_alu_mux,
               mem_mm, mem_am, mem_wme1, wb_wre, wb_wbs, wb_wm, wb_rd,
               flags_o, illegal_op, stall_cnt, flush_cnt
    );

    // Control unit side.
    modport slave (
        input  id_valid, id_opcode, id_rs1, id_rs2, id_rd, alu_flagN, alu_flagZ,
        output stall_o, flush_o, pc_sel, ex_aluop, ex_ri, ex_alu_mux,
               mem_mm, mem_am, mem_wme1, wb_wre, wb_wbs, wb_wm, wb_rd,
               flags_o, illegal_op, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipelined_control_unit.sv
// Decodes the ID opcode and carries the control word through EX/MEM/WB; owns N/Z flags, branch flush, load-use stall.
// Latency: EX fields 1 cycle after ID, MEM 2, WB 3; stall_o/flush_o are combinational from the EX register.
// Backpressure: stall_o holds the front end and injects an EX bubble; flush_o (priority) kills IF/ID; MEM/WB never stall.
module pipelined_control_unit #(
    parameter int OP_W    = 4,
    parameter int RA_W    = 4,
    parameter int ALUOP_W = 3,
    parameter int CNT_W   = 16
) (
    input  logic clk,
    input  logic rst_n,
    pipelined_control_unit_if.slave bus
);
    localparam logic [OP_W-1:0] OP_SUB  = OP_W'(0);
    localparam logic [OP_W-1:0] OP_ADD  = OP_W'(1);
    localparam logic [OP_W-1:0] OP_LSL  = OP_W'(2);
    localparam logic [OP_W-1:0] OP_NEG  = OP_W'(3);
    localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(4);
    localparam logic [OP_W-1:0] OP_BGT  = OP_W'(5);
    localparam logic [OP_W-1:0] OP_BLT  = OP_W'(6);
    localparam logic [OP_W-1:0] OP_B    = OP_W'(7);
    localparam logic [OP_W-1:0] OP_MOVI = OP_W'(8);
    localparam logic [OP_W-1:0] OP_LDR  = OP_W'(9);
    localparam logic [OP_W-1:0] OP_STR  = OP_W'(10);
    localparam logic [OP_W-1:0] OP_CMP  = OP_W'(11);
    localparam logic [OP_W-1:0] OP_MOVR = OP_W'(12);

    typedef struct packed {
        logic            wre;
        logic            wbs;
        logic            wm;
        logic [RA_W-1:0] rd;
    } wb_t;

    typedef struct packed {
        logic [1:0] mm;
        logic       am;
        logic       wme1;
        wb_t        wb;
    } mem_t;

    typedef struct packed {
        logic               valid;
        logic [OP_W-1:0]    op;
        logic [ALUOP_W-1:0] aluop;
        logic [1:0]         ri;
        logic               alu_mux;
        mem_t               mem;
    } ex_t;

    ex_t  dec, ex_d, ex_q;
    mem_t mem_q;
    wb_t  wb_q;
    logic use_rs1, use_rs2, legal;
    logic taken, stall;
    logic [1:0] flags_q;
    logic illegal_q;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    // Opcode decode; every field not named for an opcode stays 0.
    always_comb begin
        dec         = '0;
        dec.valid   = 1'b1;
        dec.op      = bus.id_opcode;
        dec.mem.wb.rd = bus.id_rd;
        use_rs1     = 1'b0;
        use_rs2     = 1'b0;
        legal       = 1'b1;
        case (bus.id_opcode)
            OP_SUB, OP_ADD, OP_LSL, OP_NEG: begin
                dec.aluop      = ALUOP_W'(bus.id_opcode);
                dec.mem.mm     = 2'b01;
                dec.mem.wb.wre = 1'b1;
                dec.mem.wb.wbs = 1'b1;
                use_rs1        = 1'b1;
                use_rs2        = (bus.id_opcode != OP_NEG);
            end
            OP_BEQ, OP_BGT, OP_BLT, OP_B: begin
                dec.ri = 2'b11;
            end
            OP_MOVI: begin
                dec.ri         = 2'b10;
                dec.mem.am     = 1'b1;
                dec.mem.wb.wre = 1'b1;
                dec.mem.wb.wbs = 1'b1;
                dec.mem.wb.wm  = 1'b1;
            end
            OP_LDR: begin
                dec.ri         = 2'b10;
                dec.mem.wb.wre = 1'b1;
                use_rs1        = 1'b1;
            end
            OP_STR: begin
                dec.aluop    = ALUOP_W'(4);
                dec.ri       = 2'b10;
                dec.mem.mm   = 2'b10;
                dec.mem.am   = 1'b1;
                dec.mem.wme1 = 1'b1;
                use_rs1      = 1'b1;
                use_rs2      = 1'b1;
            end
            OP_CMP: begin
                dec.aluop = ALUOP_W'(5);
                use_rs1   = 1'b1;
                use_rs2   = 1'b1;
            end
            OP_MOVR: begin
                dec.mem.mm     = 2'b01;
                dec.mem.wb.wre = 1'b1;
                dec.mem.wb.wbs = 1'b1;
                use_rs1        = 1'b1;
            end
            default: begin
                legal = 1'b0;
            end
        endcase
    end

    // Branch resolution in EX against the architectural flag register, and load-use detection.
    always_comb begin
        taken = 1'b0;
        if (ex_q.valid) begin
            case (ex_q.op)
                OP_B:    taken = 1'b1;
                OP_BEQ:  taken = flags_q[0];
                OP_BGT:  taken = ~flags_q[1];
                OP_BLT:  taken = flags_q[1];
                default: taken = 1'b0;
            endcase
        end
        stall = ~taken && ex_q.valid && (ex_q.op == OP_LDR) && bus.id_valid &&
                ((use_rs1 && (bus.id_rs1 == ex_q.mem.wb.rd)) ||
                 (use_rs2 && (bus.id_rs2 == ex_q.mem.wb.rd)));
        ex_d = (taken || stall || ~bus.id_valid || ~legal) ? '0 : dec;
    end

    // Stage registers: EX takes the decoded word or a bubble; MEM and WB always advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= ex_q.mem;
            wb_q  <= mem_q.wb;
        end
    end

    // Flag register loads from the ALU only when a valid cmp is in EX; illegal flag is sticky.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q   <= 2'b00;
            illegal_q <= 1'b0;
        end else begin
            if (ex_q.valid && (ex_q.op == OP_CMP))
                flags_q <= {bus.alu_flagN, bus.alu_flagZ};
            if (bus.id_valid && ~legal && ~taken)
                illegal_q <= 1'b1;
        end
    end

    // Saturating event counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall && ~&stall_cnt_q)
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (taken && ~&flush_cnt_q)
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign bus.stall_o    = stall;
    assign bus.flush_o    = taken;
    assign bus.pc_sel     = taken;
    assign bus.ex_aluop   = ex_q.aluop;
    assign bus.ex_ri      = ex_q.ri;
    assign bus.ex_alu_mux = ex_q.alu_mux;
    assign bus.mem_mm     = mem_q.mm;
    assign bus.mem_am     = mem_q.am;
    assign bus.mem_wme1   = mem_q.wme1;
    assign bus.wb_wre     = wb_q.wre;
    assign bus.wb_wbs     = wb_q.wbs;
    assign bus.wb_wm      = wb_q.wm;
    assign bus.wb_rd      = wb_q.rd;
    assign bus.flags_o    = flags_q;
    assign bus.illegal_op = illegal_q;
    assign bus.stall_cnt  = stall_cnt_q;
    assign bus.flush_cnt  = flush_cnt_q;
endmodule

// File: tb/tb_pipelined_control_unit.sv
// Bench for pipelined_control_unit: directed sequences with a WB-write scoreboard.
// Latency: expects register writes at WB exactly 3 cycles after ID acceptance.
// Backpressure: stalls/flushes are exercised explicitly; the front end holds ID while stalled.
module tb_pipelined_control_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    typedef struct {
        int       cyc;
        logic [3:0] rd;
        logic     wbs;
        logic     wm;
    } wb_exp_t;

    wb_exp_t sb[$];

    pipelined_control_unit_if #(.OP_W(4), .RA_W(4), .ALUOP_W(3), .CNT_W(16)) bus ();

    pipelined_control_unit #(.OP_W(4), .RA_W(4), .ALUOP_W(3), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ins(input logic [3:0] op, input logic [3:0] rs1, input logic [3:0] rs2,
                       input logic [3:0] rd);
        bus.id_valid  = 1'b1;
        bus.id_opcode = op;
        bus.id_rs1    = rs1;
        bus.id_rs2    = rs2;
        bus.id_rd     = rd;
    endtask

    task automatic idle();
        bus.id_valid  = 1'b0;
        bus.id_opcode = 4'h0;
        bus.id_rs1    = 4'h0;
        bus.id_rs2    = 4'h0;
        bus.id_rd     = 4'h0;
    endtask

    // Expect a register write from an instruction just accepted into EX.
    task automatic push(input logic [3:0] rd, input logic wbs, input logic wm);
        wb_exp_t e;
        e.cyc = cyc + 2;
        e.rd  = rd;
        e.wbs = wbs;
        e.wm  = wm;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        sb.delete();
        rst_n = 1'b1;
    endtask

    // WB monitor: every write-enabled WB cycle must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && bus.wb_wre) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_write", {28'd0, bus.wb_rd}, 32'hFFFF_FFFF);
            end else begin
                wb_exp_t e;
                e = sb.pop_front();
                chk("sb_wb_rd",  {28'd0, bus.wb_rd}, {28'd0, e.rd});
                chk("sb_wb_wbs", {31'd0, bus.wb_wbs}, {31'd0, e.wbs});
                chk("sb_wb_wm",  {31'd0, bus.wb_wm}, {31'd0, e.wm});
                chk("sb_wb_cyc", cyc, e.cyc);
            end
        end
    end

    initial begin
        idle();
        bus.alu_flagN = 1'b0;
        bus.alu_flagZ = 1'b0;
        repeat (3) tick();
        // Reset state while held
        chk("rst_ex_aluop", {29'd0, bus.ex_aluop}, 32'd0);
        chk("rst_wb_wre",   {31'd0, bus.wb_wre}, 32'd0);
        chk("rst_mem_wme1", {31'd0, bus.mem_wme1}, 32'd0);
        chk("rst_flags",    {30'd0, bus.flags_o}, 32'd0);
        chk("rst_stall",    {31'd0, bus.stall_o}, 32'd0);
        chk("rst_flush",    {31'd0, bus.flush_o}, 32'd0);
        chk("rst_illegal",  {31'd0, bus.illegal_op}, 32'd0);
        rst_n = 1'b1;
        tick();

        // add r1,r2,r3
        ins(4'h1, 4'd2, 4'd3, 4'd1);
        tick(); push(4'd1, 1'b1, 1'b0);
        chk("add_ex_aluop", {29'd0, bus.ex_aluop}, 32'd1);
        chk("add_ex_ri",    {30'd0, bus.ex_ri}, 32'd0);
        idle();
        tick();
        chk("add_mem_mm", {30'd0, bus.mem_mm}, 32'd1);
        tick();
        chk("add_wb_wre", {31'd0, bus.wb_wre}, 32'd1);
        chk("add_wb_rd",  {28'd0, bus.wb_rd}, 32'd1);
        repeat (3) tick();

        // ldr r4 then dependent add r5,r4,r6
        ins(4'h9, 4'd1, 4'd0, 4'd4);
        tick(); push(4'd4, 1'b0, 1'b0);
        chk("ldr_ex_ri", {30'd0, bus.ex_ri}, 32'd2);
        ins(4'h1, 4'd4, 4'd6, 4'd5);
        #1;
        chk("lu_stall", {31'd0, bus.stall_o}, 32'd1);
        chk("lu_flush", {31'd0, bus.flush_o}, 32'd0);
        tick();
        chk("lu_stall_gone", {31'd0, bus.stall_o}, 32'd0);
        chk("lu_stall_cnt",  {16'd0, bus.stall_cnt}, 32'd1);
        chk("lu_ex_bubble_ri", {30'd0, bus.ex_ri}, 32'd0);
        tick(); push(4'd5, 1'b1, 1'b0);
        chk("lu_mem_bubble", {30'd0, bus.mem_mm}, 32'd0);
        chk("lu_add_ex", {29'd0, bus.ex_aluop}, 32'd1);
        idle();
        repeat (4) tick();
        chk("lu_stall_cnt_hold", {16'd0, bus.stall_cnt}, 32'd1);

        // cmp with Z=1 then beq: taken, younger add is killed
        ins(4'hB, 4'd1, 4'd2, 4'd0);
        tick();
        chk("cmp_ex_aluop", {29'd0, bus.ex_aluop}, 32'd5);
        bus.alu_flagZ = 1'b1;
        ins(4'h4, 4'd0, 4'd0, 4'd0);
        tick();
        bus.alu_flagZ = 1'b0;
        chk("beq_flags", {30'd0, bus.flags_o}, 32'd1);
        ins(4'h1, 4'd2, 4'd3, 4'd7);
        #1;
        chk("beq_flush",  {31'd0, bus.flush_o}, 32'd1);
        chk("beq_pc_sel", {31'd0, bus.pc_sel}, 32'd1);
        tick();
        chk("beq_killed", {29'd0, bus.ex_aluop}, 32'd0);
        chk("beq_flush_off", {31'd0, bus.flush_o}, 32'd0);
        chk("beq_flush_cnt", {16'd0, bus.flush_cnt}, 32'd1);
        idle();
        repeat (3) tick();

        // cmp with Z=0 then beq: not taken
        ins(4'hB, 4'd1, 4'd2, 4'd0);
        tick();
        ins(4'h4, 4'd0, 4'd0, 4'd0);
        tick();
        chk("beq0_flags", {30'd0, bus.flags_o}, 32'd0);
        idle();
        #1;
        chk("beq0_flush", {31'd0, bus.flush_o}, 32'd0);
        tick();
        chk("beq0_flush_cnt", {16'd0, bus.flush_cnt}, 32'd1);
        repeat (3) tick();

        // cmp N=1, blt (rd field 4) in EX while a would-be dependent add sits in ID
        ins(4'hB, 4'd1, 4'd2, 4'd0);
        tick();
        bus.alu_flagN = 1'b1;
        ins(4'h6, 4'd0, 4'd0, 4'd4);
        tick();
        bus.alu_flagN = 1'b0;
        chk("blt_flags", {30'd0, bus.flags_o}, 32'd2);
        ins(4'h1, 4'd4, 4'd6, 4'd5);
        #1;
        chk("blt_flush", {31'd0, bus.flush_o}, 32'd1);
        chk("blt_stall", {31'd0, bus.stall_o}, 32'd0);
        tick();
        chk("blt_ex_bubble", {29'd0, bus.ex_aluop}, 32'd0);
        chk("blt_flush_cnt", {16'd0, bus.flush_cnt}, 32'd2);
        chk("blt_stall_cnt", {16'd0, bus.stall_cnt}, 32'd1);
        idle();
        repeat (3) tick();

        // movi and movr (highest legal opcode)
        ins(4'h8, 4'd0, 4'd0, 4'd8);
        tick(); push(4'd8, 1'b1, 1'b1);
        ins(4'hC, 4'd3, 4'd0, 4'd9);
        tick(); push(4'd9, 1'b1, 1'b0);
        chk("movr_legal", {31'd0, bus.illegal_op}, 32'd0);
        chk("movi_mem_am", {31'd0, bus.mem_am}, 32'd1);
        idle();
        repeat (4) tick();
        chk("movr_illegal_stay0", {31'd0, bus.illegal_op}, 32'd0);

        // Lowest illegal opcode 4'hD
        ins(4'hD, 4'd1, 4'd2, 4'd3);
        tick();
        chk("op_d_illegal", {31'd0, bus.illegal_op}, 32'd1);
        chk("op_d_ex_ri", {30'd0, bus.ex_ri}, 32'd0);
        idle();
        repeat (3) tick();
        do_reset();
        tick();
        chk("reset_clears_illegal", {31'd0, bus.illegal_op}, 32'd0);

        // Opcode 4'hE: nothing enabled anywhere, sticky flag
        ins(4'hE, 4'd1, 4'd2, 4'd3);
        tick();
        chk("op_e_illegal", {31'd0, bus.illegal_op}, 32'd1);
        chk("op_e_ex_aluop", {29'd0, bus.ex_aluop}, 32'd0);
        idle();
        tick();
        chk("op_e_mem_wme1", {31'd0, bus.mem_wme1}, 32'd0);
        chk("op_e_mem_mm",   {30'd0, bus.mem_mm}, 32'd0);
        tick();
        chk("op_e_wb_wre", {31'd0, bus.wb_wre}, 32'd0);
        repeat (5) tick();
        chk("op_e_sticky", {31'd0, bus.illegal_op}, 32'd1);

        // str in MEM, then asynchronous reset mid-cycle
        ins(4'hA, 4'd1, 4'd2, 4'd0);
        tick();
        chk("str_ex_aluop", {29'd0, bus.ex_aluop}, 32'd4);
        idle();
        tick();
        chk("str_mem_wme1", {31'd0, bus.mem_wme1}, 32'd1);
        chk("str_mem_mm",   {30'd0, bus.mem_mm}, 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_mem_wme1",  {31'd0, bus.mem_wme1}, 32'd0);
        chk("arst_stall_cnt", {16'd0, bus.stall_cnt}, 32'd0);
        chk("arst_flush_cnt", {16'd0, bus.flush_cnt}, 32'd0);
        chk("arst_illegal",   {31'd0, bus.illegal_op}, 32'd0);
        chk("arst_flags",     {30'd0, bus.flags_o}, 32'd0);
        #2;
        sb.delete();
        rst_n = 1'b1;
        repeat (3) tick();

        chk("sb_drained", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
